// File: rtl/banco_registros_dp_pkg.sv
// Shared definitions for the general-purpose register bank: geometry, FSM states
// and the hardwired-zero register index.
package br_pkg;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } br_state_t;

    localparam int unsigned REG_ZERO = 0;
endpackage

// File: rtl/banco_registros_dp_if.sv
// Datapath-side bus of the register bank: write port, two read ports and the
// clear request/busy pair.
interface banco_registros_dp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              clr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              busy;

    modport master (
        output clr, wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
        input  rd_data1, rd_data2, busy
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
        output rd_data1, rd_data2, busy
    );
endinterface

// File: rtl/banco_registros_dp_clr_seq.sv
// Bulk-clear sequencer: walks registers 1..NUM_REGS-1, zeroing one per clock,
// and reports busy for the whole walk.
module br_clr_seq
    import br_pkg::*;
#(
    parameter int unsigned ADDR_W = br_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

    br_state_t         state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= FIRST_ADDR;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST_ADDR) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + FIRST_ADDR;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // busy tracks the state register only; the counter never feeds it
    assign busy     = (state == CLEAR);
    assign clr_we   = (state == CLEAR);
    assign clr_addr = cnt;
endmodule

// File: rtl/banco_registros_dp.sv
// 32x32 register bank: one synchronous write port, two combinational read ports
// with same-cycle write bypass, r0 hardwired to zero, sequenced bulk clear.
module banco_registros_dp
    import br_pkg::*;
#(
    parameter int unsigned DATA_W = br_pkg::DATA_W,
    parameter int unsigned ADDR_W = br_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    banco_registros_dp_if.slave  bus
);
    localparam int unsigned      N_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [N_REGS];
    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    logic              byp_ok;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    br_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A clear request in IDLE wins over a write in the same cycle
    assign wr_ok  = bus.wr_en && !bus.clr && !busy && (bus.wr_addr != ZERO_ADDR);
    assign byp_ok = bus.wr_en && !busy && (bus.wr_addr != ZERO_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_we) begin
            regs[clr_addr] <= '0;
        end else if (wr_ok) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        rd1 = '0;
        if (!busy) begin
            if (byp_ok && (bus.wr_addr == bus.rd_addr1)) begin
                rd1 = bus.wr_data;
            end else if (bus.rd_addr1 != ZERO_ADDR) begin
                rd1 = regs[bus.rd_addr1];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (!busy) begin
            if (byp_ok && (bus.wr_addr == bus.rd_addr2)) begin
                rd2 = bus.wr_data;
            end else if (bus.rd_addr2 != ZERO_ADDR) begin
                rd2 = regs[bus.rd_addr2];
            end
        end
    end

    assign bus.rd_data1 = rd1;
    assign bus.rd_data2 = rd2;
    assign bus.busy     = busy;
endmodule
